// File: rtl/frame_copy_sequencer_if.sv
// Control and RAM-port bundle of the frame copy sequencer.
// The slave modport is the sequencer; the master modport is its environment (control FSM and RAMs).
interface frame_copy_sequencer_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic              vblank;
    logic [ADDR_W-1:0] src_rd_addr;
    logic [DATA_W-1:0] src_rd_data;
    logic [ADDR_W-1:0] dst_wr_addr;
    logic [DATA_W-1:0] dst_wr_data;
    logic              dst_wren;
    logic              busy;
    logic              done;
    logic              start_err;

    modport slave (
        input  start,
        input  abort,
        input  vblank,
        input  src_rd_data,
        output src_rd_addr,
        output dst_wr_addr,
        output dst_wr_data,
        output dst_wren,
        output busy,
        output done,
        output start_err
    );

    modport master (
        output start,
        output abort,
        output vblank,
        output src_rd_data,
        input  src_rd_addr,
        input  dst_wr_addr,
        input  dst_wr_data,
        input  dst_wren,
        input  busy,
        input  done,
        input  start_err
    );
endinterface

// File: rtl/frame_copy_sequencer.sv
// Streams one frame from a fixed-latency source RAM into display RAM, one pixel per clock,
// optionally deferring the copy to the next vertical-blank rising edge.
module frame_copy_sequencer #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int PIXELS      = 76800,
    parameter int RD_LATENCY  = 2,
    parameter int SYNC_VBLANK = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_srst,
    frame_copy_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_VB = 2'd1;
    localparam logic [1:0] ST_STREAM  = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_vb_meta;
    logic              r_vb_sync;
    logic              r_vb_prev;
    logic              w_vb_rise;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [ADDR_W-1:0] r_pipe_addr [RD_LATENCY];
    logic              w_pipe_empty;
    logic              w_push;
    logic              w_abort;
    logic              w_done;
    logic              w_start_err;
    logic [ADDR_W-1:0] r_dst_wr_addr;
    logic [DATA_W-1:0] r_dst_wr_data;
    logic              r_dst_wren;
    logic              r_busy;
    logic              r_done;
    logic              r_start_err;

    // vblank crosses from the pixel clock domain: two flops, then a third for edge detect
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vb_meta <= 1'b0;
            r_vb_sync <= 1'b0;
            r_vb_prev <= 1'b0;
        end else if (i_srst) begin
            r_vb_meta <= 1'b0;
            r_vb_sync <= 1'b0;
            r_vb_prev <= 1'b0;
        end else begin
            r_vb_meta <= bus.vblank;
            r_vb_sync <= r_vb_meta;
            r_vb_prev <= r_vb_sync;
        end
    end

    assign w_vb_rise    = r_vb_sync & ~r_vb_prev;
    assign w_pipe_empty = ~(|r_pipe_vld);

    // Next-state decode; abort outranks everything once a copy is in flight
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        w_start_err = 1'b0;
        if (r_state == ST_IDLE) begin
            if (bus.start && !bus.abort) begin
                if (SYNC_VBLANK != 0) begin
                    w_state_nxt = ST_WAIT_VB;
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else if (bus.abort) begin
            w_abort     = 1'b1;
            w_state_nxt = ST_IDLE;
        end else begin
            w_start_err = bus.start;
            case (r_state)
                ST_WAIT_VB: begin
                    if (w_vb_rise) begin
                        w_state_nxt = ST_STREAM;
                    end else begin
                        w_state_nxt = ST_WAIT_VB;
                    end
                end
                ST_STREAM: begin
                    if (r_rd_addr == LAST_ADDR) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    // empty pipe here means the final write is on the bus this cycle
                    if (w_pipe_empty) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_push = (r_state == ST_STREAM) && !w_abort;

    // State, status pulses and the read-address counter (saturates at the last pixel)
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else if (i_srst) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done;
            r_start_err <= w_start_err;
            if (w_state_nxt == ST_IDLE) begin
                r_rd_addr <= '0;
            end else if ((r_state == ST_STREAM) && (r_rd_addr != LAST_ADDR)) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end else begin
                r_rd_addr <= r_rd_addr;
            end
        end
    end

    // Valid/address delay line matching the source RAM read latency
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_addr[i] <= '0;
            end
        end else if (i_srst || w_abort) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= w_push;
            r_pipe_addr[0] <= r_rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    // Registered destination write port, fed by the pipe output and the returning read data
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dst_wren    <= 1'b0;
            r_dst_wr_addr <= '0;
            r_dst_wr_data <= '0;
        end else if (i_srst) begin
            r_dst_wren    <= 1'b0;
            r_dst_wr_addr <= '0;
            r_dst_wr_data <= '0;
        end else if (w_abort) begin
            r_dst_wren    <= 1'b0;
            r_dst_wr_addr <= r_dst_wr_addr;
            r_dst_wr_data <= r_dst_wr_data;
        end else if (r_pipe_vld[RD_LATENCY-1]) begin
            r_dst_wren    <= 1'b1;
            r_dst_wr_addr <= r_pipe_addr[RD_LATENCY-1];
            r_dst_wr_data <= bus.src_rd_data;
        end else begin
            r_dst_wren    <= 1'b0;
            r_dst_wr_addr <= r_dst_wr_addr;
            r_dst_wr_data <= r_dst_wr_data;
        end
    end

    assign bus.src_rd_addr = r_rd_addr;
    assign bus.dst_wr_addr = r_dst_wr_addr;
    assign bus.dst_wr_data = r_dst_wr_data;
    assign bus.dst_wren    = r_dst_wren;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.start_err   = r_start_err;
endmodule

// File: tb/tb_frame_copy_sequencer.sv
// Bench for frame_copy_sequencer: four instances (PIXELS=16) covering immediate, vblank-synchronised
// and latency-1/4 variants, each fed by a source RAM model returning src[a] = a ^ 8'hA5.
module tb_frame_copy_sequencer;
    localparam int AW = 17;
    localparam int DW = 8;

    typedef struct {
        int dut;        // 0: sync0/L2, 1: sync1/L2, 2: sync0/L1, 3: sync0/L4
        int vb;         // cycle after start at which vblank rises (-1: never)
        int vb_pre;     // 1: vblank already high at start, falls at cycle 15
        int abort_at;   // cycle after start carrying abort (-1: none)
        int restart_at; // cycle after start carrying a second start (-1: none)
        int n_wr;       // expected number of writes
        int n_done;     // expected number of done pulses
        int exp_first;  // cycle of first write relative to start
        int exp_done;   // cycle of first done relative to start (-1: none)
        int exp_err;    // cycle of start_err relative to start (-1: none)
    } vec_t;

    typedef struct {
        int dut;
        int addr;
        int data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic srst = 1'b0;
    logic [3:0] start_s = 4'd0;
    logic [3:0] abort_s = 4'd0;
    logic vblank_s = 1'b0;
    int cyc = 0;
    int n_vec = 0;
    int n_mis = 0;

    logic [3:0] wren_s, busy_s, done_s, err_s;
    logic [AW-1:0] raddr_s [4];
    logic [AW-1:0] waddr_s [4];
    logic [DW-1:0] wdata_s [4];
    int wr_cnt [4], done_cnt [4], err_cnt [4], first_wr [4], done_cyc [4], err_cyc [4];
    exp_t exp_q [$];
    exp_t mon_e;
    vec_t vecs [9];

    frame_copy_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    frame_copy_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    frame_copy_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    frame_copy_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    frame_copy_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PIXELS(16), .RD_LATENCY(2), .SYNC_VBLANK(0))
        dut0 (.i_clock(clk), .i_reset_n(rst_n), .i_srst(srst), .bus(bus0));
    frame_copy_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PIXELS(16), .RD_LATENCY(2), .SYNC_VBLANK(1))
        dut1 (.i_clock(clk), .i_reset_n(rst_n), .i_srst(srst), .bus(bus1));
    frame_copy_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PIXELS(16), .RD_LATENCY(1), .SYNC_VBLANK(0))
        dut2 (.i_clock(clk), .i_reset_n(rst_n), .i_srst(srst), .bus(bus2));
    frame_copy_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PIXELS(16), .RD_LATENCY(4), .SYNC_VBLANK(0))
        dut3 (.i_clock(clk), .i_reset_n(rst_n), .i_srst(srst), .bus(bus3));

    assign bus0.start = start_s[0];  assign bus0.abort = abort_s[0];  assign bus0.vblank = 1'b0;
    assign bus1.start = start_s[1];  assign bus1.abort = abort_s[1];  assign bus1.vblank = vblank_s;
    assign bus2.start = start_s[2];  assign bus2.abort = abort_s[2];  assign bus2.vblank = 1'b0;
    assign bus3.start = start_s[3];  assign bus3.abort = abort_s[3];  assign bus3.vblank = 1'b0;

    assign wren_s = {bus3.dst_wren, bus2.dst_wren, bus1.dst_wren, bus0.dst_wren};
    assign busy_s = {bus3.busy, bus2.busy, bus1.busy, bus0.busy};
    assign done_s = {bus3.done, bus2.done, bus1.done, bus0.done};
    assign err_s  = {bus3.start_err, bus2.start_err, bus1.start_err, bus0.start_err};
    assign raddr_s[0] = bus0.src_rd_addr;  assign waddr_s[0] = bus0.dst_wr_addr;  assign wdata_s[0] = bus0.dst_wr_data;
    assign raddr_s[1] = bus1.src_rd_addr;  assign waddr_s[1] = bus1.dst_wr_addr;  assign wdata_s[1] = bus1.dst_wr_data;
    assign raddr_s[2] = bus2.src_rd_addr;  assign waddr_s[2] = bus2.dst_wr_addr;  assign wdata_s[2] = bus2.dst_wr_data;
    assign raddr_s[3] = bus3.src_rd_addr;  assign waddr_s[3] = bus3.dst_wr_addr;  assign wdata_s[3] = bus3.dst_wr_data;

    // Source RAM models: address delay lines of the matching read latency
    logic [AW-1:0] dl0 [2];
    logic [AW-1:0] dl1 [2];
    logic [AW-1:0] dl2 [1];
    logic [AW-1:0] dl3 [4];
    always @(posedge clk) begin
        dl0[0] <= bus0.src_rd_addr;  dl0[1] <= dl0[0];
        dl1[0] <= bus1.src_rd_addr;  dl1[1] <= dl1[0];
        dl2[0] <= bus2.src_rd_addr;
        dl3[0] <= bus3.src_rd_addr;  dl3[1] <= dl3[0];  dl3[2] <= dl3[1];  dl3[3] <= dl3[2];
    end
    assign bus0.src_rd_data = dl0[1][7:0] ^ 8'hA5;
    assign bus1.src_rd_data = dl1[1][7:0] ^ 8'hA5;
    assign bus2.src_rd_data = dl2[0][7:0] ^ 8'hA5;
    assign bus3.src_rd_data = dl3[3][7:0] ^ 8'hA5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every write pops one expected {dut, addr, data}
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 4; d++) begin
                if (wren_s[d]) begin
                    wr_cnt[d]++;
                    if (first_wr[d] < 0) first_wr[d] = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write_dut", d, -1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("wr_dut", d, mon_e.dut);
                        chk("wr_addr", int'(waddr_s[d]), mon_e.addr);
                        chk("wr_data", int'(wdata_s[d]), mon_e.data);
                    end
                end
                if (done_s[d]) begin
                    done_cnt[d]++;
                    if (done_cyc[d] < 0) done_cyc[d] = cyc;
                end
                if (err_s[d]) begin
                    err_cnt[d]++;
                    if (err_cyc[d] < 0) err_cyc[d] = cyc;
                end
            end
        end
    end

    task automatic clear_counts(input int d);
        wr_cnt[d] = 0;  done_cnt[d] = 0;  err_cnt[d] = 0;
        first_wr[d] = -1;  done_cyc[d] = -1;  err_cyc[d] = -1;
    endtask

    task automatic run_vec(input vec_t v);
        int s;
        int d;
        d = v.dut;
        clear_counts(d);
        for (int k = 0; k < v.n_wr; k++) exp_q.push_back('{d, k % 16, (k % 16) ^ 8'hA5});
        if (v.vb_pre != 0) begin
            vblank_s = 1'b1;
            repeat (10) tick();
        end
        s = cyc;
        start_s[d] = 1'b1;
        tick();
        for (int c = 1; c <= 80; c++) begin
            if (c == 1) chk("busy_after_start", int'(busy_s[d]), 1);
            if (v.abort_at >= 0 && c == v.abort_at + 1) begin
                chk("busy_after_abort", int'(busy_s[d]), 0);
                chk("wren_after_abort", int'(wren_s[d]), 0);
            end
            start_s[d] = (c == v.restart_at);
            abort_s[d] = (c == v.abort_at);
            if (v.vb_pre != 0) vblank_s = (c < 15) || (c >= v.vb && c < v.vb + 20);
            else if (v.vb >= 0) vblank_s = (c >= v.vb && c < v.vb + 20);
            else vblank_s = 1'b0;
            tick();
        end
        start_s[d] = 1'b0;
        abort_s[d] = 1'b0;
        vblank_s = 1'b0;
        chk("write_count", wr_cnt[d], v.n_wr);
        chk("first_write_cycle", first_wr[d] - s, v.exp_first);
        chk("done_count", done_cnt[d], v.n_done);
        if (v.exp_done >= 0) chk("done_cycle", done_cyc[d] - s, v.exp_done);
        chk("start_err_count", err_cnt[d], (v.exp_err >= 0) ? 1 : 0);
        if (v.exp_err >= 0) chk("start_err_cycle", err_cyc[d] - s, v.exp_err);
        chk("busy_at_end", int'(busy_s[d]), 0);
        chk("scoreboard_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        //          dut vb vbp abort rst  nwr nd first done err
        vecs[0] = '{0, -1, 0, -1,  -1, 16, 1,  4, 20, -1};
        vecs[1] = '{2, -1, 0, -1,  -1, 16, 1,  3, 19, -1};
        vecs[2] = '{3, -1, 0, -1,  -1, 16, 1,  6, 22, -1};
        vecs[3] = '{1, 40, 0, -1,  -1, 16, 1, 46, 62, -1};
        vecs[4] = '{1, 30, 1, -1,  -1, 16, 1, 36, 52, -1};
        vecs[5] = '{0, -1, 0, 11,  -1,  8, 0,  4, -1, -1};
        vecs[6] = '{0, -1, 0, -1,  -1, 16, 1,  4, 20, -1};
        vecs[7] = '{0, -1, 0, -1,   5, 16, 1,  4, 20,  6};
        vecs[8] = '{0, -1, 0, -1,  20, 32, 2,  4, 20, -1};
        for (int d = 0; d < 4; d++) clear_counts(d);

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 4; d++) begin
            chk("reset_outputs_zero",
                int'({wren_s[d], busy_s[d], done_s[d], err_s[d], |raddr_s[d], |waddr_s[d], |wdata_s[d]}), 0);
        end

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // start and abort together in IDLE: abort wins, nothing happens
        clear_counts(0);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        repeat (25) tick();
        chk("start_with_abort_busy", int'(busy_s[0]), 0);
        chk("start_with_abort_writes", wr_cnt[0], 0);
        chk("start_with_abort_err", err_cnt[0], 0);

        // asynchronous reset in the middle of a stream
        clear_counts(0);
        for (int k = 0; k < 16; k++) exp_q.push_back('{0, k, k ^ 8'hA5});
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (8) tick();
        chk("mid_stream_busy_before_reset", int'(busy_s[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_stream_outputs_zero",
            int'({wren_s[0], busy_s[0], done_s[0], err_s[0], |raddr_s[0], |waddr_s[0], |wdata_s[0]}), 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("after_reset_busy", int'(busy_s[0]), 0);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
